// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - pipeline writeback stage: W register bank, result select and load extraction.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module writeback_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             validM,
    input  logic             stallW,
    input  logic             flushW,
    input  logic             RegWriteM,
    input  logic [4:0]       RdM,
    input  logic [1:0]       ResultSrcM,
    input  logic [2:0]       LoadTypeM,
    input  logic [XLEN-1:0]  ALU_ResultM,
    input  logic [XLEN-1:0]  ReadDataM,
    input  logic [XLEN-1:0]  PCPlus4M,
    input  logic [XLEN-1:0]  ImmExtM,
    output logic             RegWriteW,
    output logic [4:0]       RdW,
    output logic [XLEN-1:0]  ResultW,
`ifdef WB_RETIRE_CNT_EN
    output logic [CNT_W-1:0] RetireCountW,
`endif
    output logic             validW
);

    localparam int OFF_W = (XLEN == 64) ? 3 : 2;
    localparam logic [OFF_W-1:0] HALF_MASK = {{(OFF_W-1){1'b1}}, 1'b0};
    localparam logic [OFF_W-1:0] WORD_MASK = OFF_W'((XLEN == 64) ? 4 : 0);

    if (!(XLEN == 32 || XLEN == 64) || CNT_W < 1) begin : g_bad_param
        $error("writeback_stage: XLEN must be 32 or 64 and CNT_W at least 1");
    end

    logic            regwrite_q;
    logic [4:0]      rd_q;
    logic [1:0]      result_src_q;
    logic [2:0]      load_type_q;
    logic [XLEN-1:0] alu_q;
    logic [XLEN-1:0] rdata_q;
    logic [XLEN-1:0] pc4_q;
    logic [XLEN-1:0] imm_q;
    logic            valid_q;
    logic            valid_d;

    // A flush kills the slot even while stalled; the data fields only track the enable.
    always_comb begin
        valid_d = valid_q;
        if (flushW)
            valid_d = 1'b0;
        else if (!stallW)
            valid_d = validM;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regwrite_q   <= 1'b0;
            rd_q         <= '0;
            result_src_q <= '0;
            load_type_q  <= '0;
            alu_q        <= '0;
            rdata_q      <= '0;
            pc4_q        <= '0;
            imm_q        <= '0;
            valid_q      <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (!stallW) begin
                regwrite_q   <= RegWriteM;
                rd_q         <= RdM;
                result_src_q <= ResultSrcM;
                load_type_q  <= LoadTypeM;
                alu_q        <= ALU_ResultM;
                rdata_q      <= ReadDataM;
                pc4_q        <= PCPlus4M;
                imm_q        <= ImmExtM;
            end
        end
    end

    logic [OFF_W-1:0] off;
    logic [7:0]       byte_v;
    logic [15:0]      half_v;
    logic [31:0]      word_v;
    logic [XLEN-1:0]  load_data;

    assign off    = alu_q[OFF_W-1:0];
    assign byte_v = 8'(rdata_q >> {off, 3'b000});
    assign half_v = 16'(rdata_q >> {off & HALF_MASK, 3'b000});
    assign word_v = 32'(rdata_q >> {off & WORD_MASK, 3'b000});

    // funct3[2] selects zero extension; 011 and 111 pass the whole word through.
    always_comb begin
        load_data = rdata_q;
        case (load_type_q)
            3'b000:  load_data = XLEN'($signed(byte_v));
            3'b001:  load_data = XLEN'($signed(half_v));
            3'b010:  load_data = XLEN'($signed(word_v));
            3'b100:  load_data = XLEN'(byte_v);
            3'b101:  load_data = XLEN'(half_v);
            3'b110:  load_data = XLEN'(word_v);
            default: load_data = rdata_q;
        endcase
    end

    always_comb begin
        ResultW = alu_q;
        case (result_src_q)
            2'b00:   ResultW = alu_q;
            2'b01:   ResultW = load_data;
            2'b10:   ResultW = pc4_q;
            default: ResultW = imm_q;
        endcase
    end

    assign RdW       = rd_q;
    assign validW    = valid_q;
    assign RegWriteW = regwrite_q & valid_q & (rd_q != 5'd0);

`ifdef WB_RETIRE_CNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign cnt_d = (valid_q && !stallW) ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign RetireCountW = cnt_q;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - directed self-checking bench for writeback_stage (XLEN 32 and 64 instances).
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        validM = 1'b0;
    logic        stallW = 1'b0;
    logic        flushW = 1'b0;
    logic        RegWriteM = 1'b0;
    logic [4:0]  RdM = '0;
    logic [1:0]  ResultSrcM = '0;
    logic [2:0]  LoadTypeM = '0;
    logic [63:0] alu = '0;
    logic [63:0] rdata = '0;
    logic [63:0] pc4 = '0;
    logic [63:0] imm = '0;

    logic        rw32, rw64, v32, v64;
    logic [4:0]  rd32, rd64;
    logic [31:0] res32;
    logic [63:0] res64;
`ifdef WB_RETIRE_CNT_EN
    logic [3:0]  cnt32;
    logic [63:0] cnt64;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    writeback_stage #(.XLEN(32), .CNT_W(4)) u32 (
        .clk(clk), .rst(rst), .validM(validM), .stallW(stallW), .flushW(flushW),
        .RegWriteM(RegWriteM), .RdM(RdM), .ResultSrcM(ResultSrcM), .LoadTypeM(LoadTypeM),
        .ALU_ResultM(alu[31:0]), .ReadDataM(rdata[31:0]), .PCPlus4M(pc4[31:0]), .ImmExtM(imm[31:0]),
        .RegWriteW(rw32), .RdW(rd32), .ResultW(res32),
`ifdef WB_RETIRE_CNT_EN
        .RetireCountW(cnt32),
`endif
        .validW(v32)
    );

    writeback_stage #(.XLEN(64)) u64 (
        .clk(clk), .rst(rst), .validM(validM), .stallW(stallW), .flushW(flushW),
        .RegWriteM(RegWriteM), .RdM(RdM), .ResultSrcM(ResultSrcM), .LoadTypeM(LoadTypeM),
        .ALU_ResultM(alu), .ReadDataM(rdata), .PCPlus4M(pc4), .ImmExtM(imm),
        .RegWriteW(rw64), .RdW(rd64), .ResultW(res64),
`ifdef WB_RETIRE_CNT_EN
        .RetireCountW(cnt64),
`endif
        .validW(v64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input logic v, input logic rw, input logic [4:0] rd,
                         input logic [1:0] src, input logic [2:0] lt);
        validM     = v;
        RegWriteM  = rw;
        RdM        = rd;
        ResultSrcM = src;
        LoadTypeM  = lt;
    endtask

    initial begin
        #2 rst = 1'b1;
        #1;
        chk("rst_valid", 64'(v32), 64'h0);
        chk("rst_regwrite", 64'(rw32), 64'h0);
        chk("rst_rd", 64'(rd32), 64'h0);
        chk("rst_result", 64'(res32), 64'h0);
        chk("rst_result64", res64, 64'h0);
        step();
        rst = 1'b0;

        // XLEN=32 load extraction
        rdata = 64'h0000_0000_8070_6050;
        alu   = 64'h0000_0000_0000_1003;
        set_m(1'b1, 1'b1, 5'd5, 2'b01, 3'b000);
        step();
        chk("lb_off3", 64'(res32), 64'hFFFF_FF80);
        chk("lb_regwrite", 64'(rw32), 64'h1);
        chk("lb_rd", 64'(rd32), 64'h5);
        chk("lb_valid", 64'(v32), 64'h1);
        LoadTypeM = 3'b100; step();
        chk("lbu_off3", 64'(res32), 64'h0000_0080);
        LoadTypeM = 3'b001; step();
        chk("lh_off3", 64'(res32), 64'hFFFF_8070);
        alu = 64'h1000; LoadTypeM = 3'b101; step();
        chk("lhu_off0", 64'(res32), 64'h0000_6050);
        LoadTypeM = 3'b010; step();
        chk("lw32", 64'(res32), 64'h8070_6050);
        LoadTypeM = 3'b110; step();
        chk("lwu32", 64'(res32), 64'h8070_6050);
        alu = 64'h1001; LoadTypeM = 3'b011; step();
        chk("ld32_full", 64'(res32), 64'h8070_6050);
        LoadTypeM = 3'b111; step();
        chk("f7_full", 64'(res32), 64'h8070_6050);

        // result source select
        alu = 64'h1234_5678; set_m(1'b1, 1'b1, 5'd7, 2'b00, 3'b000); step();
        chk("src_alu", 64'(res32), 64'h1234_5678);
        imm = 64'hDEAD_BEEF; ResultSrcM = 2'b11; step();
        chk("src_imm", 64'(res32), 64'hDEAD_BEEF);
        pc4 = 64'h104; set_m(1'b1, 1'b1, 5'd0, 2'b10, 3'b000); step();
        chk("x0_result", 64'(res32), 64'h104);
        chk("x0_regwrite", 64'(rw32), 64'h0);
        chk("x0_valid", 64'(v32), 64'h1);
        set_m(1'b1, 1'b0, 5'd3, 2'b10, 3'b000); step();
        chk("norw_regwrite", 64'(rw32), 64'h0);
        set_m(1'b0, 1'b1, 5'd3, 2'b10, 3'b000); step();
        chk("inv_valid", 64'(v32), 64'h0);
        chk("inv_regwrite", 64'(rw32), 64'h0);

        // stall hold, then flush during stall, then flush without stall
        pc4 = 64'h200; set_m(1'b1, 1'b1, 5'd9, 2'b10, 3'b000); step();
        chk("cap_rd", 64'(rd32), 64'h9);
        stallW = 1'b1; pc4 = 64'h300; set_m(1'b1, 1'b1, 5'd4, 2'b00, 3'b000);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_rd", 64'(rd32), 64'h9);
            chk("stall_result", 64'(res32), 64'h200);
            chk("stall_regwrite", 64'(rw32), 64'h1);
        end
        flushW = 1'b1; step();
        chk("flushstall_valid", 64'(v32), 64'h0);
        chk("flushstall_regwrite", 64'(rw32), 64'h0);
        chk("flushstall_rd", 64'(rd32), 64'h9);
        stallW = 1'b0; ResultSrcM = 2'b10; step();
        chk("flush_valid", 64'(v32), 64'h0);
        chk("flush_rd", 64'(rd32), 64'h4);
        chk("flush_result", 64'(res32), 64'h300);
        chk("flush_regwrite", 64'(rw32), 64'h0);
        flushW = 1'b0;

        // XLEN=64 load extraction
        rdata = 64'hFFFF_FFFF_8000_0001; alu = 64'h2000;
        set_m(1'b1, 1'b1, 5'd10, 2'b01, 3'b110); step();
        chk("lwu64_off0", res64, 64'h0000_0000_8000_0001);
        chk("lwu64_regwrite", 64'(rw64), 64'h1);
        LoadTypeM = 3'b010; step();
        chk("lw64_off0", res64, 64'hFFFF_FFFF_8000_0001);
        rdata = 64'h8000_0001_0000_0002; alu = 64'h2004; LoadTypeM = 3'b110; step();
        chk("lwu64_off4", res64, 64'h0000_0000_8000_0001);
        alu = 64'h2007; LoadTypeM = 3'b000; step();
        chk("lb64_off7", res64, 64'hFFFF_FFFF_FFFF_FF80);
        alu = 64'h2006; LoadTypeM = 3'b101; step();
        chk("lhu64_off6", res64, 64'h0000_0000_0000_8000);
        LoadTypeM = 3'b011; step();
        chk("ld64", res64, 64'h8000_0001_0000_0002);

        // asynchronous reset mid-operation
        alu = 64'h55; set_m(1'b1, 1'b1, 5'd6, 2'b00, 3'b000); step();
        chk("pre_rst_regwrite", 64'(rw32), 64'h1);
        rst = 1'b1; #1;
        chk("async_rst_valid", 64'(v32), 64'h0);
        chk("async_rst_regwrite", 64'(rw32), 64'h0);
        chk("async_rst_result", 64'(res32), 64'h0);
        chk("async_rst_rd64", 64'(rd64), 64'h0);
        step();
        chk("in_rst_regwrite", 64'(rw32), 64'h0);
        rst = 1'b0; validM = 1'b0; step();
        chk("post_rst_regwrite", 64'(rw32), 64'h0);

`ifdef WB_RETIRE_CNT_EN
        chk("cnt_start", 64'(cnt32), 64'h0);
        set_m(1'b1, 1'b1, 5'd1, 2'b00, 3'b000);
        for (int i = 0; i < 18; i++) step();
        chk("cnt_wrap", 64'(cnt32), 64'h1);
        chk("cnt64", cnt64, 64'd17);
        rst = 1'b1; #1;
        chk("cnt_rst", 64'(cnt32), 64'h0);
        chk("cnt_rst_valid", 64'(v32), 64'h0);
        step();
        rst = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 and 64 only.
REQ-002 Parameter CNT_W, default 64, retire-counter width.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 validM  input  1  M-stage instruction valid.
REQ-006 stallW  input  1  hold W register contents.
REQ-007 flushW  input  1  kill the instruction entering W.
REQ-008 RegWriteM  input  1  register-file write request.
REQ-009 RdM  input  5  destination register index.
REQ-010 ResultSrcM  input  2  result select: 00 ALU, 01 load, 10 PC+4, 11 immediate.
REQ-011 LoadTypeM  input  3  load funct3.
REQ-012 ALU_ResultM, ReadDataM, PCPlus4M, ImmExtM  input  XLEN each  candidate results; ALU_ResultM is also the load address.
REQ-013 RegWriteW  output  1  qualified register-file write enable.
REQ-014 RdW  output  5  registered destination index.
REQ-015 ResultW  output  XLEN  writeback data.
REQ-016 validW  output  1  W-stage instruction valid.
REQ-017 RetireCountW  output  CNT_W  retired-instruction count; present only with WB_RETIRE_CNT_EN.

Function
REQ-018 Each rising clk edge with stallW=0: the RegWrite, Rd, ResultSrc, LoadType, ALU_Result, ReadData, PCPlus4 and ImmExt fields of the M stage shall be captured into W registers; validW <= validM & ~flushW.
REQ-019 With stallW=1 and flushW=0, all W registers shall hold their values.
REQ-020 flushW=1 shall clear validW on the next edge regardless of stallW; data registers follow REQ-018/019.
REQ-021 Latency: ResultW, RdW and RegWriteW shall reflect an M-stage instruction exactly one cycle after capture; ResultW is combinational from the W registers.
REQ-022 ResultW selection: 00 ALU_Result, 01 extracted load data, 10 PCPlus4, 11 ImmExt.
REQ-023 Load lane offset = ALU_Result[1:0] when XLEN=32, ALU_Result[2:0] when XLEN=64; byte select uses the full offset; halfword select ignores offset bit 0; word select (XLEN=64) ignores offset bits 1:0.
REQ-024 funct3 000 LB / 001 LH / 010 LW shall sign-extend; 100 LBU / 101 LHU / 110 LWU shall zero-extend.
REQ-025 When XLEN=32, LW and LWU shall return the full word unextended; 011 (LD) shall return the full XLEN word; 111 shall return the full XLEN word.
REQ-026 RegWriteW = RegWrite register & validW & (RdW != 0); writes to x0 are suppressed.
REQ-027 Simultaneous flushW and stallW: flush wins for validW; no write is issued for the killed slot.

Reset
REQ-028 rst=1 shall clear all W registers asynchronously: validW=0, RegWriteW=0, RdW=0, ResultW=0, and RetireCountW=0 when present.
REQ-029 Reset asserted mid-operation shall discard the in-flight W instruction; no write is issued during or after reset until a new valid capture.

Configuration
REQ-030 With macro WB_RETIRE_CNT_EN defined, RetireCountW shall exist and shall increment by 1 on each edge where validW=1 and stallW=0, wrapping from all-ones to 0.
REQ-031 Without WB_RETIRE_CNT_EN, the RetireCountW port and counter logic shall be absent; all other behaviour is unchanged.

Verification
REQ-032 XLEN=32, LB, ReadData=0x8070_6050, addr low bits 2'b11 -> ResultW=0xFFFF_FF80; LBU -> 0x0000_0080.
REQ-033 XLEN=32, LH, ReadData=0x8070_6050, addr low bits 2'b11 -> ResultW=0xFFFF_8070 (bit 0 ignored); LHU at 2'b00 -> 0x0000_6050.
REQ-034 RegWriteM=1, RdM=0, ResultSrc=10, PCPlus4=0x104 -> ResultW=0x104, RegWriteW=0.
REQ-035 Valid instruction captured, then stallW=1 for 3 cycles -> RdW and ResultW stable for 3 cycles; flushW=1 together with stallW -> validW=0 and RegWriteW=0 next cycle.
REQ-036 WB_RETIRE_CNT_EN defined, CNT_W=4: 17 valid unstalled retirements from reset -> RetireCountW=1 (wrap); rst pulse mid-stream -> RetireCountW=0 and validW=0 immediately.
REQ-037 XLEN=64, LWU, ReadData=0xFFFF_FFFF_8000_0001, addr low bits 3'b000 -> ResultW=0x0000_0000_8000_0001; LW -> 0xFFFF_FFFF_8000_0001.
